// File: rtl/axi_lite_pkg.sv
// Shared definitions for the AXI4-Lite initiator: response codes, protection default,
// full strobe and the master FSM state encoding.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY    = 2'b00;
    localparam logic [1:0] RESP_EXOKAY  = 2'b01;
    localparam logic [1:0] RESP_SLVERR  = 2'b10;
    localparam logic [1:0] RESP_DECERR  = 2'b11;

    localparam logic [2:0] PROT_DEFAULT = 3'b000;
    localparam logic [3:0] STRB_ALL     = 4'hF;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        WR_RESP,
        RD_ADDR,
        RD_DATA,
        RESP
    } state_e;

endpackage

// File: rtl/axi_lite_wdog.sv
// Transaction watchdog for axi_lite_master: counts busy cycles since command accept and
// flags the cycle in which the count reaches TIMEOUT_CYCLES.
module axi_lite_wdog #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_run,
    output logic o_expired
);
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_count;

    // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_count <= '0;
        end else if (i_run) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    // Fires in the busy cycle whose increment brings the count to TIMEOUT_CYCLES.
    assign o_expired = i_run && (r_count == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/axi_lite_master.sv
// AXI4-Lite initiator: one user command becomes one AXI-Lite write or read, result returned
// on a valid/ready port. Define AXI_MST_TIMEOUT_EN to add the axi_lite_wdog watchdog.
module axi_lite_master
    import axi_lite_pkg::*;
#(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic              axi_clk,
    input  logic              axi_rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic [3:0]        cmd_wstrb,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_write,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [1:0]        rsp_resp,
    output logic              rsp_timeout,
    output logic [ADDR_W-1:0] axi_awaddr,
    output logic [2:0]        axi_awprot,
    output logic              axi_awvalid,
    input  logic              axi_awready,
    output logic [DATA_W-1:0] axi_wdata,
    output logic [3:0]        axi_wstrb,
    output logic              axi_wvalid,
    input  logic              axi_wready,
    input  logic [1:0]        axi_bresp,
    input  logic              axi_bvalid,
    output logic              axi_bready,
    output logic [ADDR_W-1:0] axi_araddr,
    output logic [2:0]        axi_arprot,
    output logic              axi_arvalid,
    input  logic              axi_arready,
    input  logic [DATA_W-1:0] axi_rdata,
    input  logic [1:0]        axi_rresp,
    input  logic              axi_rvalid,
    output logic              axi_rready
);
    typedef struct packed {
        logic              cmd_ready;
        logic [ADDR_W-1:0] awaddr;
        logic              awvalid;
        logic [DATA_W-1:0] wdata;
        logic [3:0]        wstrb;
        logic              wvalid;
        logic              bready;
        logic [ADDR_W-1:0] araddr;
        logic              arvalid;
        logic              rready;
        logic              rsp_valid;
        logic              rsp_write;
        logic [DATA_W-1:0] rsp_rdata;
        logic [1:0]        rsp_resp;
    } out_regs_t;

    state_e    r_state;
    state_e    w_state_nxt;
    out_regs_t r_q;
    out_regs_t w_d;
    logic      w_accept;
    logic      w_aw_pend;
    logic      w_w_pend;
    logic      w_timed_out;

    assign w_accept  = (r_state == IDLE) && cmd_valid;
    assign w_aw_pend = r_q.awvalid && !axi_awready;
    assign w_w_pend  = r_q.wvalid && !axi_wready;

    always_ff @(posedge axi_clk) begin
        if (axi_rst) begin
            r_state       <= IDLE;
            r_q           <= '0;
            r_q.cmd_ready <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_q     <= w_d;
        end
    end

    always_comb begin
        // NOTE: hold-by-default assignments come first so no branch can leave a latch behind.
        w_state_nxt = r_state;
        w_d         = r_q;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_d.cmd_ready = 1'b0;
                    if (cmd_write) begin
                        w_d.awaddr  = cmd_addr;
                        w_d.wdata   = cmd_wdata;
                        w_d.wstrb   = cmd_wstrb;
                        w_d.awvalid = 1'b1;
                        w_d.wvalid  = 1'b1;
                        w_state_nxt = WR;
                    end else begin
                        w_d.araddr  = cmd_addr;
                        w_d.arvalid = 1'b1;
                        w_state_nxt = RD_ADDR;
                    end
                end
            end
            WR: begin
                // AW and W retire independently; B is only awaited once both are done.
                w_d.awvalid = w_aw_pend;
                w_d.wvalid  = w_w_pend;
                if (!w_aw_pend && !w_w_pend) begin
                    w_d.bready  = 1'b1;
                    w_state_nxt = WR_RESP;
                end
            end
            WR_RESP: begin
                if (axi_bvalid) begin
                    w_d.bready    = 1'b0;
                    w_d.rsp_valid = 1'b1;
                    w_d.rsp_write = 1'b1;
                    w_d.rsp_rdata = '0;
                    w_d.rsp_resp  = axi_bresp;
                    w_state_nxt   = RESP;
                end
            end
            RD_ADDR: begin
                if (axi_arready) begin
                    w_d.arvalid = 1'b0;
                    w_d.rready  = 1'b1;
                    w_state_nxt = RD_DATA;
                end
            end
            RD_DATA: begin
                if (axi_rvalid) begin
                    w_d.rready    = 1'b0;
                    w_d.rsp_valid = 1'b1;
                    w_d.rsp_write = 1'b0;
                    w_d.rsp_rdata = axi_rdata;
                    w_d.rsp_resp  = axi_rresp;
                    w_state_nxt   = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    w_d.rsp_valid = 1'b0;
                    w_d.cmd_ready = 1'b1;
                    w_state_nxt   = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // Watchdog expiry overrides whatever the channel logic decided this cycle.
        if (w_timed_out) begin
            w_d.awvalid   = 1'b0;
            w_d.wvalid    = 1'b0;
            w_d.bready    = 1'b0;
            w_d.arvalid   = 1'b0;
            w_d.rready    = 1'b0;
            w_d.rsp_valid = 1'b1;
            w_d.rsp_write = (r_state == WR) || (r_state == WR_RESP);
            w_d.rsp_rdata = '0;
            w_d.rsp_resp  = RESP_SLVERR;
            w_state_nxt   = RESP;
        end
    end

`ifdef AXI_MST_TIMEOUT_EN
    logic w_wdog_run;
    logic r_rsp_timeout;

    assign w_wdog_run = (r_state == WR) || (r_state == WR_RESP) ||
                        (r_state == RD_ADDR) || (r_state == RD_DATA);

    axi_lite_wdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wdog (
        .i_clk     (axi_clk),
        .i_rst     (axi_rst),
        .i_clear   (w_accept),
        .i_run     (w_wdog_run),
        .o_expired (w_timed_out)
    );

    always_ff @(posedge axi_clk) begin
        if (axi_rst) begin
            r_rsp_timeout <= 1'b0;
        end else if ((w_state_nxt == RESP) && (r_state != RESP)) begin
            r_rsp_timeout <= w_timed_out;
        end
    end

    assign rsp_timeout = r_rsp_timeout;
`else
    logic w_unused_timeout_cfg;

    assign w_unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign w_timed_out          = 1'b0;
    assign rsp_timeout          = 1'b0;
`endif

    assign cmd_ready   = r_q.cmd_ready;
    assign rsp_valid   = r_q.rsp_valid;
    assign rsp_write   = r_q.rsp_write;
    assign rsp_rdata   = r_q.rsp_rdata;
    assign rsp_resp    = r_q.rsp_resp;
    assign axi_awaddr  = r_q.awaddr;
    assign axi_awprot  = PROT_DEFAULT;
    assign axi_awvalid = r_q.awvalid;
    assign axi_wdata   = r_q.wdata;
    assign axi_wstrb   = r_q.wstrb;
    assign axi_wvalid  = r_q.wvalid;
    assign axi_bready  = r_q.bready;
    assign axi_araddr  = r_q.araddr;
    assign axi_arprot  = PROT_DEFAULT;
    assign axi_arvalid = r_q.arvalid;
    assign axi_rready  = r_q.rready;

endmodule
